vga_timing_gen_v2: RTL and testbench
====================================

Name: vga_timing_gen_v2

Overview:
- Parametrised video timing generator that succeeds the fixed 640x480 controller inside the display peripheral.
- Adds:
  - per-axis programmable porch, sync and active widths
  - a runtime pixel-clock divider
  - an enable gate
  - a frame counter
  - sticky line-match and vblank interrupts
- Drives pix_x/pix_y/visible into pattern generators and supplies irq sources and status to the peripheral register file.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CNT_W, 10, pix_x/pix_y width; must hold H_TOTAL-1 and V_TOTAL-1
DIV_W, 4, pixel divider width
FRAME_W, 16, frame counter width

Ports:
clk  in  1  system clock (64 MHz)
reset  in  1  synchronous, active-high reset
enable  in  1  1 = run timing; 0 = hold at origin
hpol  in  1  hsync active level (0 = negative, 1 = positive)
vpol  in  1  vsync active level
pix_div  in  DIV_W  pixel period = pix_div+1 clk cycles
line_match  in  CNT_W  line number for irq_line
irq_line_clr  in  1  clears irq_line
irq_vblank_clr  in  1  clears irq_vblank
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
visible  out  1  current pixel inside active area
pix_x  out  CNT_W  horizontal counter
pix_y  out  CNT_W  vertical counter
pix_stb  out  1  last clk of current pixel period
frame_start  out  1  one-clk pulse on wrap to (0,0)
frame_count  out  FRAME_W  completed-frame count
irq_line  out  1  sticky line-match flag
irq_vblank  out  1  sticky vblank-entry flag

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined likewise.
- Reset: pix_x=0, pix_y=0, prescaler=0, visible=0, pix_stb=0, frame_start=0, frame_count=0, irq_line=0, irq_vblank=0; internal sync-active flags=0, so hsync=~hpol and vsync=~vpol.
- Polarity: hsync = hs_act XNOR hpol, where hs_act is a registered internal flag; vsync uses vpol the same way. Polarity changes take effect combinationally.
- Prescaler:
  - counts 0..pix_div.
  - pix_stb=1 while prescaler==pix_div and enable=1.
  - On the clk after pix_stb, pix_x advances and the prescaler returns to 0.
  - pix_div=0 gives pix_stb=1 every enabled cycle.
  - A pix_div change mid-pixel: if prescaler > new pix_div, the pixel ends on the next clk.
- Counters:
  - pix_x wraps H_TOTAL-1 -> 0 and increments pix_y.
  - pix_y wraps V_TOTAL-1 -> 0.
- Registered decodes, valid in the same cycle as the pix_x/pix_y they describe:
  - visible = (pix_x<H_ACTIVE) && (pix_y<V_ACTIVE)
  - hs_act = H_ACTIVE+H_FP <= pix_x < H_ACTIVE+H_FP+H_SYNC
  - vs_act = V_ACTIVE+V_FP <= pix_y < V_ACTIVE+V_FP+V_SYNC; vs_act is line-based and independent of pix_x.
- Events: raised only on a counter advance into the named position. The position held after reset or enable assertion does not count.
  - frame_start: one clk, on the first cycle at (0,0) after wrap from (H_TOTAL-1,V_TOTAL-1). frame_count increments in the same cycle and wraps modulo 2^FRAME_W.
  - irq_line: set on the first cycle at (0,line_match). Never fires if line_match >= V_TOTAL.
  - irq_vblank: set on the first cycle at (0,V_ACTIVE).
  - Both irqs are sticky until the matching *_clr pulse. Set and clear in the same cycle: set wins.
- Enable:
  - enable=0 forces, on the next clk: pix_x=pix_y=0, prescaler=0, visible=0, hs_act=vs_act=0, pix_stb=0.
  - frame_count and irq flags are retained while disabled.
  - On re-enable, the first pixel (0,0) lasts pix_div+1 clks.
- Reset mid-frame: all state returns to reset values on the next clk, regardless of enable.

Test Plan:
- Default params, enable=1, pix_div=0, hpol=vpol=0:
  - hsync=0 exactly for pix_x 656..751, else 1
  - vsync=0 for pix_y 490..491
  - visible=1 iff x<640 && y<480
- Run 3 frames at pix_div=0:
  - frame_start pulses every 420000 clks
  - frame_count reads 1, then 2, then 3
  - the initial (0,0) after reset produces no pulse
- pix_div=2:
  - pix_stb high every 3rd clk
  - pix_x holds 3 clks per value
  - frame period 1260000 clks
- line_match=100:
  - irq_line rises on the first clk at (0,100)
  - irq_line_clr asserted in that same cycle leaves it 1; clr one clk later drops it to 0
  - line_match=600 never sets it
- irq_vblank rises at (0,480); with vpol=1, vsync is high for lines 490..491 only.
- Enable low at (300,200):
  - next clk: pix_x=pix_y=0, visible=0, hsync=~hpol
  - frame_count unchanged
  - re-enable resumes from (0,0)
- Reset asserted mid-frame: frame_count and both irqs clear to 0 on the next clk.

Source files
------------

// File: rtl/vga_timing_gen_v2.sv
// Programmable video timing generator: per-axis porch/sync/active widths, runtime
// pixel-clock divider, enable gate, frame counter and sticky line/vblank interrupts.
module vga_timing_gen_v2 #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned DIV_W    = 4,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               hpol_i,
  input  logic               vpol_i,
  input  logic [DIV_W-1:0]   pix_div_i,
  input  logic [CNT_W-1:0]   line_match_i,
  input  logic               irq_line_clr_i,
  input  logic               irq_vblank_clr_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               visible_o,
  output logic [CNT_W-1:0]   pix_x_o,
  output logic [CNT_W-1:0]   pix_y_o,
  output logic               pix_stb_o,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_count_o,
  output logic               irq_line_o,
  output logic               irq_vblank_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic               vis_q, vis_d;
  logic               hs_q, hs_d, vs_q, vs_d;
  logic               fs_q, fs_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic               irq_line_q, irq_line_d, irq_vb_q, irq_vb_d;
  logic               line_hit_q, line_hit_d, vb_hit_q, vb_hit_d;

  logic               stb_c;
  logic [CNT_W-1:0]   nx_c, ny_c;

  // Pixel ends this clk; a prescaler already past a lowered divider ends it at once
  assign stb_c = enable_i & ~reset_i & (presc_q >= pix_div_i);

  // Position the raster moves to when the current pixel ends
  always_comb begin
    nx_c = x_q + CNT_W'(1);
    ny_c = y_q;
    if (x_q == H_LAST) begin
      nx_c = '0;
      ny_c = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
    end
  end

  // Next-state: prescaler, counters, registered decodes, events and sticky irqs
  always_comb begin
    presc_d    = presc_q;
    x_d        = x_q;
    y_d        = y_q;
    vis_d      = vis_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    fs_d       = 1'b0;
    fcnt_d     = fcnt_q;
    line_hit_d = 1'b0;
    vb_hit_d   = 1'b0;
    // A clear in the very cycle an irq fires loses to that set
    irq_line_d = irq_line_q & (~irq_line_clr_i | line_hit_q);
    irq_vb_d   = irq_vb_q & (~irq_vblank_clr_i | vb_hit_q);

    if (!enable_i) begin
      presc_d = '0;
      x_d     = '0;
      y_d     = '0;
      vis_d   = 1'b0;
      hs_d    = 1'b0;
      vs_d    = 1'b0;
    end else if (stb_c) begin
      presc_d = '0;
      x_d     = nx_c;
      y_d     = ny_c;
      vis_d   = (nx_c < H_VIS) && (ny_c < V_VIS);
      hs_d    = (nx_c >= HS_FIRST) && (nx_c <= HS_LAST);
      vs_d    = (ny_c >= VS_FIRST) && (ny_c <= VS_LAST);
      if (nx_c == '0) begin
        if (ny_c == '0) begin
          fs_d   = 1'b1;
          fcnt_d = fcnt_q + FRAME_W'(1);
        end
        if (ny_c == line_match_i) begin
          line_hit_d = 1'b1;
          irq_line_d = 1'b1;
        end
        if (ny_c == V_VIS) begin
          vb_hit_d = 1'b1;
          irq_vb_d = 1'b1;
        end
      end
    end else begin
      presc_d = presc_q + DIV_W'(1);
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      vis_q      <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      fs_q       <= 1'b0;
      fcnt_q     <= '0;
      irq_line_q <= 1'b0;
      irq_vb_q   <= 1'b0;
      line_hit_q <= 1'b0;
      vb_hit_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vis_q      <= vis_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      fs_q       <= fs_d;
      fcnt_q     <= fcnt_d;
      irq_line_q <= irq_line_d;
      irq_vb_q   <= irq_vb_d;
      line_hit_q <= line_hit_d;
      vb_hit_q   <= vb_hit_d;
    end
  end

  assign hsync_o       = ~(hs_q ^ hpol_i);
  assign vsync_o       = ~(vs_q ^ vpol_i);
  assign visible_o     = vis_q;
  assign pix_x_o       = x_q;
  assign pix_y_o       = y_q;
  assign pix_stb_o     = stb_c;
  assign frame_start_o = fs_q;
  assign frame_count_o = fcnt_q;
  assign irq_line_o    = irq_line_q;
  assign irq_vblank_o  = irq_vb_q;

endmodule

// File: tb/tb_vga_timing_gen_v2.sv
// Bench for vga_timing_gen_v2 on a reduced raster (15x13) so whole frames stay short.
module tb_vga_timing_gen_v2;

  localparam int unsigned HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int unsigned VA = 6, VF = 2, VSW = 2, VB = 3;
  localparam int unsigned CW = 4, DW = 3, FW = 3;
  localparam int unsigned HT = HA + HF + HSW + HB;  // 15
  localparam int unsigned VT = VA + VF + VSW + VB;  // 13
  localparam int unsigned FP = HT * VT;             // 195 pixels per frame

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          hpol = 1'b0;
  logic          vpol = 1'b0;
  logic [DW-1:0] pix_div = '0;
  logic [CW-1:0] line_match = '0;
  logic          irq_line_clr = 1'b0;
  logic          irq_vblank_clr = 1'b0;
  logic          hsync, vsync, visible, pix_stb, frame_start, irq_line, irq_vblank;
  logic [CW-1:0] pix_x, pix_y;
  logic [FW-1:0] frame_count;

  vga_timing_gen_v2 #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .CNT_W(CW), .DIV_W(DW), .FRAME_W(FW)
  ) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .hpol_i(hpol), .vpol_i(vpol),
    .pix_div_i(pix_div), .line_match_i(line_match),
    .irq_line_clr_i(irq_line_clr), .irq_vblank_clr_i(irq_vblank_clr),
    .hsync_o(hsync), .vsync_o(vsync), .visible_o(visible),
    .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_stb_o(pix_stb),
    .frame_start_o(frame_start), .frame_count_o(frame_count),
    .irq_line_o(irq_line), .irq_vblank_o(irq_vblank)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n clock edges; land 1 time unit after the last one
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go(1);
    reset = 1'b0;
  endtask

  // ---------------- reference model: raster as a linear pixel index ----------------
  int m_n, m_presc, m_fcnt;
  bit m_fresh, m_fs, m_il, m_iv, m_lh, m_vh;

  function automatic bit in_rng(input int v, input int lo, input int len);
    return (v >= lo) && (v < lo + len);
  endfunction

  function automatic logic [31:0] model_exp();
    int ex, ey;
    bit vis, hs, vs, stb;
    ex  = m_n % HT;
    ey  = m_n / HT;
    vis = !m_fresh && (ex < HA) && (ey < VA);
    hs  = in_rng(ex, HA + HF, HSW) ? hpol : !hpol;
    vs  = in_rng(ey, VA + VF, VSW) ? vpol : !vpol;
    stb = enable && !reset && (m_presc >= int'(pix_div));
    return 32'({CW'(ex), CW'(ey), vis, hs, vs, stb, m_fs, FW'(m_fcnt), m_il, m_iv});
  endfunction

  task automatic model_step();
    int nx, ny;
    bit stb;
    stb = enable && !reset && (m_presc >= int'(pix_div));
    if (reset) begin
      m_n = 0; m_presc = 0; m_fcnt = 0; m_fresh = 1'b1;
      m_fs = 1'b0; m_il = 1'b0; m_iv = 1'b0; m_lh = 1'b0; m_vh = 1'b0;
    end else begin
      m_il = m_il && (!irq_line_clr || m_lh);
      m_iv = m_iv && (!irq_vblank_clr || m_vh);
      m_lh = 1'b0; m_vh = 1'b0; m_fs = 1'b0;
      if (!enable) begin
        m_n = 0; m_presc = 0; m_fresh = 1'b1;
      end else if (stb) begin
        m_n = (m_n + 1) % FP;
        m_presc = 0;
        m_fresh = 1'b0;
        nx = m_n % HT;
        ny = m_n / HT;
        if (m_n == 0) begin
          m_fs = 1'b1;
          m_fcnt = (m_fcnt + 1) % (1 << FW);
        end
        if (nx == 0 && ny == int'(line_match)) begin m_il = 1'b1; m_lh = 1'b1; end
        if (nx == 0 && ny == VA) begin m_iv = 1'b1; m_vh = 1'b1; end
      end else begin
        m_presc++;
      end
    end
  endtask

  // ---------------- decode vectors reached from reset ----------------
  typedef struct {
    int div; bit hp; bit vp; int x; int y;
    bit hs; bit vs; bit vis;
  } vec_t;
  vec_t tbl[13];

  int pulses[$];
  int fcs[$];
  int first_fs, cnt;
  int en_off;

  initial begin
    tbl[0]  = '{0, 1'b0, 1'b0,  7,  5, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{0, 1'b0, 1'b0,  8,  5, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{0, 1'b0, 1'b0, 10,  0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1, 1'b0, 1'b0, 12,  3, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{0, 1'b0, 1'b0, 13,  3, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{0, 1'b0, 1'b0,  9,  3, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{0, 1'b0, 1'b0,  0,  8, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{0, 1'b0, 1'b0, 14,  9, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{0, 1'b0, 1'b0,  0, 10, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{2, 1'b1, 1'b1, 11,  8, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1, 1'b1, 1'b0,  3,  7, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{3, 1'b0, 1'b1,  0,  6, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1, 1'b1, 1'b1,  7,  0, 1'b0, 1'b0, 1'b1};

    enable = 1'b1;
    foreach (tbl[i]) begin
      pix_div = DW'(tbl[i].div);
      hpol = tbl[i].hp;
      vpol = tbl[i].vp;
      do_reset();
      go((tbl[i].y * HT + tbl[i].x) * (tbl[i].div + 1));
      #2;
      chk($sformatf("vec%0d", i), 32'({pix_x, pix_y, hsync, vsync, visible}),
          32'({CW'(tbl[i].x), CW'(tbl[i].y), tbl[i].hs, tbl[i].vs, tbl[i].vis}));
    end

    // Reset state (reset still held, enable high)
    hpol = 1'b1; vpol = 1'b0; pix_div = '0;
    reset = 1'b1;
    go(1); #2;
    chk("rst_pos", 32'({pix_x, pix_y}), 32'd0);
    chk("rst_flags", 32'({visible, pix_stb, frame_start, irq_line, irq_vblank}), 32'd0);
    chk("rst_fcnt", 32'(frame_count), 32'd0);
    chk("rst_sync", 32'({hsync, vsync}), 32'b01);
    reset = 1'b0;

    // Three frames at pix_div=0: pulses at 195, 390, 585, none at the initial origin
    hpol = 1'b0;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      #2;
      if (frame_start) begin pulses.push_back(k); fcs.push_back(int'(frame_count)); end
      go(1);
    end
    chk("frm_npulse", 32'(pulses.size()), 32'd3);
    for (int i = 0; i < pulses.size() && i < 3; i++) begin
      chk($sformatf("frm_at%0d", i), 32'(pulses[i]), 32'(FP * (i + 1)));
      chk($sformatf("frm_cnt%0d", i), 32'(fcs[i]), 32'(i + 1));
    end

    // pix_div=2: strobe every 3rd clk, 3 clks per pixel, 3x frame period
    pix_div = 3'd2;
    do_reset();
    first_fs = -1;
    for (int k = 0; k < 700; k++) begin
      #2;
      if (k < 30) begin
        chk($sformatf("div2_stb%0d", k), 32'(pix_stb), 32'((k % 3) == 2));
        chk($sformatf("div2_x%0d", k), 32'(pix_x), 32'(k / 3));
      end
      if (frame_start && first_fs < 0) first_fs = k;
      go(1);
    end
    chk("div2_period", 32'(first_fs), 32'(3 * FP));

    // Lowering pix_div below the running prescaler ends the pixel on the next clk
    pix_div = 3'd3;
    do_reset();
    go(2); #2;
    chk("divchg_pre", 32'(pix_stb), 32'd0);
    pix_div = 3'd1;
    #1;
    chk("divchg_stb", 32'(pix_stb), 32'd1);
    go(1); #2;
    chk("divchg_x", 32'({pix_x, pix_stb}), 32'({CW'(1), 1'b0}));
    go(1); #2;
    chk("divchg_x2", 32'({pix_x, pix_stb}), 32'({CW'(1), 1'b1}));

    // irq_line at (0,3): same-cycle clear ignored, later clear works; then vblank
    pix_div = '0; line_match = 4'd3;
    do_reset();
    go(44); #2;
    chk("line_before", 32'(irq_line), 32'd0);
    go(1); #2;
    chk("line_pos", 32'({pix_x, pix_y}), 32'({CW'(0), CW'(3)}));
    chk("line_set", 32'(irq_line), 32'd1);
    irq_line_clr = 1'b1;
    go(1); #2;
    chk("line_clr_same", 32'(irq_line), 32'd1);
    go(1); #2;
    chk("line_clr_next", 32'(irq_line), 32'd0);
    irq_line_clr = 1'b0;
    go(42); #2;
    chk("vb_before", 32'(irq_vblank), 32'd0);
    go(1); #2;
    chk("vb_pos", 32'({pix_x, pix_y}), 32'({CW'(0), CW'(VA)}));
    chk("vb_set", 32'(irq_vblank), 32'd1);
    go(1);
    irq_vblank_clr = 1'b1;
    go(1);
    irq_vblank_clr = 1'b0;
    #2;
    chk("vb_clr", 32'(irq_vblank), 32'd0);

    // Out-of-range line_match never fires; the last line does
    line_match = 4'd14;
    do_reset();
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      #2;
      cnt += int'(irq_line);
      go(1);
    end
    chk("line_oor", 32'(cnt), 32'd0);
    line_match = 4'd12;
    do_reset();
    go(179); #2;
    chk("line_last_pre", 32'(irq_line), 32'd0);
    go(1); #2;
    chk("line_last", 32'(irq_line), 32'd1);

    // Disable at (5,4) of the second frame, then re-enable with pix_div=1
    hpol = 1'b1; vpol = 1'b0; line_match = '0; pix_div = '0;
    do_reset();
    go(FP + 4 * HT + 5); #2;
    chk("dis_pos", 32'({pix_x, pix_y, visible}), 32'({CW'(5), CW'(4), 1'b1}));
    chk("dis_fcnt_pre", 32'(frame_count), 32'd1);
    enable = 1'b0;
    go(1); #2;
    chk("dis_state", 32'({pix_x, pix_y, visible, pix_stb, hsync, vsync}), 32'({CW'(0), CW'(0), 4'b0001}));
    chk("dis_fcnt", 32'(frame_count), 32'd1);
    go(3); #2;
    chk("dis_hold", 32'({pix_x, pix_y, frame_count}), 32'({CW'(0), CW'(0), FW'(1)}));
    enable = 1'b1; pix_div = 3'd1;
    #1;
    chk("reen_stb0", 32'(pix_stb), 32'd0);
    go(1); #2;
    chk("reen_hold", 32'({pix_x, pix_y, pix_stb, frame_start}), 32'({CW'(0), CW'(0), 2'b10}));
    go(1); #2;
    chk("reen_adv", 32'({pix_x, pix_y, visible, frame_count}), 32'({CW'(1), CW'(0), 1'b1, FW'(1)}));

    // Reset mid-frame clears counter and irqs, even with enable low
    pix_div = '0; line_match = 4'd2;
    do_reset();
    go(FP + 100); #2;
    chk("mid_pre", 32'({frame_count, irq_line, irq_vblank}), 32'({FW'(1), 2'b11}));
    reset = 1'b1; enable = 1'b0;
    go(1); #2;
    chk("mid_rst", 32'({frame_count, irq_line, irq_vblank, pix_x, pix_y}), 32'd0);
    reset = 1'b0; enable = 1'b1;

    // Randomized run against the reference model
    en_off = 0;
    for (int c = 0; c < 30000; c++) begin
      reset = (c == 0) || ($urandom_range(0, 2999) == 0);
      if (en_off > 0) begin
        enable = 1'b0;
        en_off--;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 799) == 0) en_off = int'($urandom_range(1, 5));
      end
      if ($urandom_range(0, 299) == 0)
        pix_div = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) hpol = ~hpol;
      if ($urandom_range(0, 499) == 0) vpol = ~vpol;
      if ($urandom_range(0, 399) == 0) line_match = CW'($urandom_range(0, 15));
      irq_line_clr   = ($urandom_range(0, 19) == 0);
      irq_vblank_clr = ($urandom_range(0, 19) == 0);
      #2;
      if (c > 0)
        chk($sformatf("rand%0d", c),
            32'({pix_x, pix_y, visible, hsync, vsync, pix_stb, frame_start, frame_count, irq_line, irq_vblank}),
            model_exp());
      @(posedge clk);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got %0d tests, expected completion", n_tests);
    $fatal(1);
  end

endmodule
